// File: rtl/ssp_dma_ctrl_if.sv
// Handshake bundle between the SSP FIFOs / DMA engine and the per-channel
// request controller. LW must match the controller's LW parameter.
interface ssp_dma_ctrl_if #(
    parameter int NCH = 2,
    parameter int LW  = 4
);
    logic [NCH-1:0]    en;
    logic [NCH*LW-1:0] level;
    logic [NCH*LW-1:0] wmark;
    logic [NCH-1:0]    clr;
    logic [NCH-1:0]    tc;
    logic [NCH-1:0]    sreq;
    logic [NCH-1:0]    breq;
    logic [NCH-1:0]    done;
    logic [NCH*16-1:0] xcnt;

    // DMA / FIFO side: drives enables, levels and completion, sees requests
    modport master (
        output en, level, wmark, clr, tc,
        input  sreq, breq, done, xcnt
    );

    // Request controller side
    modport slave (
        input  en, level, wmark, clr, tc,
        output sreq, breq, done, xcnt
    );
endinterface

// File: rtl/ssp_dma_ctrl.sv
// SSP DMA request controller: one independent request FSM per channel.
// TX channels request on free FIFO space, RX channels on FIFO occupancy.
//
// state | meaning
// ------+-----------------------------------------------------------
// OFF   | channel disabled, requests and done low, xcnt held
// IDLE  | enabled, waiting for a single or burst condition
// REQ   | requests sticky-set by their conditions, waiting for clr
// HOLD  | one dead cycle after clr, requests low
// DONE  | terminal count seen, done high until the channel is disabled
//
// After clr the requests stay low for two cycles: the HOLD cycle and the
// first REQ cycle, whose requests are then set from that cycle's conditions.
module ssp_dma_ctrl #(
    parameter int             NCH    = 2,
    parameter int             DEPTH  = 8,
    parameter int             LW     = $clog2(DEPTH) + 1,
    parameter logic [NCH-1:0] TXMASK = 'b01
) (
    input  logic         PCLK,
    input  logic         PRESETn,
    ssp_dma_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        ST_OFF  = 3'd0,
        ST_IDLE = 3'd1,
        ST_REQ  = 3'd2,
        ST_HOLD = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        state_t        state_q, state_d;
        logic          sreq_q, sreq_d;
        logic          breq_q, breq_d;
        logic          done_q, done_d;
        logic [15:0]   xcnt_q, xcnt_d;
        logic [LW-1:0] level_in, wmark_in, level_sat, space;
        logic          burst_ok, single_c, burst_c;

        assign level_in = bus.level[i*LW +: LW];
        assign wmark_in = bus.wmark[i*LW +: LW];

        // Saturate the level and derive the single/burst request conditions
        always_comb begin
            level_sat = (level_in > DEPTH_L) ? DEPTH_L : level_in;
            space     = DEPTH_L - level_sat;
            burst_ok  = (wmark_in != '0) && (wmark_in <= DEPTH_L);
            if (TXMASK[i]) begin
                single_c = (space != '0);
                burst_c  = burst_ok && (space >= wmark_in);
            end else begin
                single_c = (level_sat != '0);
                burst_c  = burst_ok && (level_sat >= wmark_in);
            end
        end

        // Next state and next registered outputs; en=0 overrides everything
        always_comb begin
            state_d = state_q;
            sreq_d  = sreq_q;
            breq_d  = breq_q;
            done_d  = done_q;
            xcnt_d  = xcnt_q;
            if (!bus.en[i]) begin
                state_d = ST_OFF;
                sreq_d  = 1'b0;
                breq_d  = 1'b0;
                done_d  = 1'b0;
            end else begin
                case (state_q)
                    ST_OFF: begin
                        state_d = ST_IDLE;
                        xcnt_d  = '0;
                        done_d  = 1'b0;
                    end
                    ST_IDLE: begin
                        if (single_c || burst_c) begin
                            state_d = ST_REQ;
                            sreq_d  = single_c;
                            breq_d  = burst_c;
                        end
                    end
                    ST_REQ: begin
                        if (bus.clr[i]) begin
                            sreq_d  = 1'b0;
                            breq_d  = 1'b0;
                            xcnt_d  = xcnt_q + 16'd1;
                            state_d = bus.tc[i] ? ST_DONE : ST_HOLD;
                            done_d  = bus.tc[i];
                        end else begin
                            sreq_d = sreq_q | single_c;
                            breq_d = breq_q | burst_c;
                        end
                    end
                    ST_HOLD: begin
                        sreq_d  = 1'b0;
                        breq_d  = 1'b0;
                        state_d = (single_c || burst_c) ? ST_REQ : ST_IDLE;
                    end
                    ST_DONE: begin
                        sreq_d = 1'b0;
                        breq_d = 1'b0;
                        done_d = 1'b1;
                    end
                    default: begin
                        state_d = ST_OFF;
                        sreq_d  = 1'b0;
                        breq_d  = 1'b0;
                        done_d  = 1'b0;
                    end
                endcase
            end
        end

        // Channel state and registered outputs, cleared asynchronously
        always_ff @(posedge PCLK or negedge PRESETn) begin
            if (!PRESETn) begin
                state_q <= ST_OFF;
                sreq_q  <= 1'b0;
                breq_q  <= 1'b0;
                done_q  <= 1'b0;
                xcnt_q  <= '0;
            end else begin
                state_q <= state_d;
                sreq_q  <= sreq_d;
                breq_q  <= breq_d;
                done_q  <= done_d;
                xcnt_q  <= xcnt_d;
            end
        end

        assign bus.sreq[i]          = sreq_q;
        assign bus.breq[i]          = breq_q;
        assign bus.done[i]          = done_q;
        assign bus.xcnt[i*16 +: 16] = xcnt_q;
    end

endmodule
